// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU: op codes, flag bit positions, FSM states.
package seq_alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_MUL = 5'd2,
        OP_DIV = 5'd3,
        OP_MOD = 5'd4,
        OP_AND = 5'd5,
        OP_OR  = 5'd6,
        OP_XOR = 5'd7,
        OP_SLL = 5'd8,
        OP_SRL = 5'd9
    } op_t;

    localparam int FLG_N = 4;
    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_V = 1;
    localparam int FLG_E = 0;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result bundle between the register-file side (master) and the ALU (slave).
// Q_hi exists only when SEQ_ALU_MULHI_EN is defined.
interface seq_alu_if #(parameter int N = 4);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [4:0]   ALUControl;
    logic         out_valid;
    logic [N-1:0] Q;
    logic [4:0]   F;
`ifdef SEQ_ALU_MULHI_EN
    logic [N-1:0] Q_hi;

    modport master (
        output in_valid, A, B, ALUControl,
        input  in_ready, out_valid, Q, F, Q_hi
    );

    modport slave (
        input  in_valid, A, B, ALUControl,
        output in_ready, out_valid, Q, F, Q_hi
    );
`else
    modport master (
        output in_valid, A, B, ALUControl,
        input  in_ready, out_valid, Q, F
    );

    modport slave (
        input  in_valid, A, B, ALUControl,
        output in_ready, out_valid, Q, F
    );
`endif

endinterface

// File: rtl/seq_alu_iter.sv
// Shared 2N-bit shift register running N iterations of shift-add multiply or restoring divide.
// Outputs show the value after the current iteration, so they are final while done is high.
module seq_alu_iter #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode_div,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder
);

    localparam int CW = $clog2(N + 1);

    logic          busy;
    logic [CW-1:0] cnt;
    logic          div_r;
    logic [N-1:0]  dvs;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;
    logic [N-1:0]  nxt_hi;
    logic [N-1:0]  nxt_lo;
    logic [N:0]    sum;
    logic [N:0]    shl;
    logic [N:0]    diff;

    // Multiply keeps the multiplier in lo and shifts the partial product in from the top;
    // divide shifts the dividend out of lo into the remainder in hi, quotient bits enter lo.
    always_comb begin
        sum    = {1'b0, hi} + {1'b0, dvs};
        shl    = {hi, lo[N-1]};
        diff   = shl - {1'b0, dvs};
        nxt_hi = hi;
        nxt_lo = lo;
        if (div_r) begin
            if (!diff[N]) begin
                nxt_hi = diff[N-1:0];
                nxt_lo = {lo[N-2:0], 1'b1};
            end else begin
                nxt_hi = shl[N-1:0];
                nxt_lo = {lo[N-2:0], 1'b0};
            end
        end else if (lo[0]) begin
            nxt_hi = sum[N:1];
            nxt_lo = {sum[0], lo[N-1:1]};
        end else begin
            nxt_hi = {1'b0, hi[N-1:1]};
            nxt_lo = {hi[0], lo[N-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            div_r <= 1'b0;
            dvs   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            div_r <= mode_div;
            dvs   <= b;
            hi    <= '0;
            lo    <= a;
        end else if (busy) begin
            hi <= nxt_hi;
            lo <= nxt_lo;
            if (cnt == CW'(N - 1)) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign done      = busy && (cnt == CW'(N - 1));
    assign product   = {nxt_hi, nxt_lo};
    assign quotient  = nxt_lo;
    assign remainder = nxt_hi;

endmodule

// File: rtl/seq_alu.sv
// Registered N-bit ALU: single-cycle add/sub/logic/shift, N-iteration mul/div/mod.
// Define SEQ_ALU_MULHI_EN to expose the high product half on bus.Q_hi.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_alu_if.slave   bus
);

    localparam logic [N:0] NV = (N + 1)'(N);

    state_t         state;
    state_t         next_state;
    logic [4:0]     op_r;
    logic           out_valid_r;
    logic [N-1:0]   q_r;
    logic [4:0]     f_r;

    logic [N:0]     sum;
    logic [N:0]     diff;
    logic           b_nz;
    logic           big_shift;
    logic           multi;
    logic [N-1:0]   sc_q;
    logic           sc_c;
    logic           sc_v;
    logic           sc_e;

    logic           it_done;
    logic [2*N-1:0] it_product;
    logic [N-1:0]   it_quotient;
    logic [N-1:0]   it_remainder;
    logic [N-1:0]   it_q;
    logic           it_v;

    logic           start;
    logic           wr;
    logic [N-1:0]   wr_q;
    logic           wr_c;
    logic           wr_v;
    logic           wr_e;

`ifdef SEQ_ALU_MULHI_EN
    logic [N-1:0]   qhi_r;
    logic [N-1:0]   it_hi;
    logic [N-1:0]   wr_hi;
`endif

    seq_alu_iter #(.N(N)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode_div  (bus.ALUControl != OP_MUL),
        .a         (bus.A),
        .b         (bus.B),
        .done      (it_done),
        .product   (it_product),
        .quotient  (it_quotient),
        .remainder (it_remainder)
    );

    // Single-cycle results; mul/div/mod only raise 'multi' unless B==0 lets them finish now.
    always_comb begin
        sum       = {1'b0, bus.A} + {1'b0, bus.B};
        diff      = {1'b0, bus.A} - {1'b0, bus.B};
        b_nz      = |bus.B;
        big_shift = ({1'b0, bus.B} >= NV);
        multi     = 1'b0;
        sc_q      = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        sc_e      = 1'b0;
        case (bus.ALUControl)
            OP_ADD: begin
                sc_q = sum[N-1:0];
                sc_c = sum[N];
                sc_v = (bus.A[N-1] == bus.B[N-1]) && (sum[N-1] != bus.A[N-1]);
            end
            OP_SUB: begin
                sc_q = diff[N-1:0];
                sc_c = ~diff[N];
                sc_v = (bus.A[N-1] != bus.B[N-1]) && (diff[N-1] != bus.A[N-1]);
            end
            OP_MUL: multi = b_nz;
            OP_DIV: begin
                multi = b_nz;
                sc_q  = '1;
                sc_e  = ~b_nz;
            end
            OP_MOD: begin
                multi = b_nz;
                sc_q  = bus.A;
                sc_e  = ~b_nz;
            end
            OP_AND: sc_q = bus.A & bus.B;
            OP_OR:  sc_q = bus.A | bus.B;
            OP_XOR: sc_q = bus.A ^ bus.B;
            OP_SLL: sc_q = big_shift ? '0 : (bus.A << bus.B);
            OP_SRL: sc_q = big_shift ? '0 : (bus.A >> bus.B);
            default: sc_e = 1'b1;
        endcase
    end

    always_comb begin
        it_q = it_product[N-1:0];
        if (op_r == OP_DIV) begin
            it_q = it_quotient;
        end else if (op_r == OP_MOD) begin
            it_q = it_remainder;
        end
        it_v = (op_r == OP_MUL) && (|it_product[2*N-1:N]);
`ifdef SEQ_ALU_MULHI_EN
        it_hi = (op_r == OP_MUL) ? it_product[2*N-1:N] : '0;
`endif
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        wr         = 1'b0;
        wr_q       = '0;
        wr_c       = 1'b0;
        wr_v       = 1'b0;
        wr_e       = 1'b0;
`ifdef SEQ_ALU_MULHI_EN
        wr_hi      = '0;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (multi) begin
                        start      = 1'b1;
                        next_state = ITER;
                    end else begin
                        wr   = 1'b1;
                        wr_q = sc_q;
                        wr_c = sc_c;
                        wr_v = sc_v;
                        wr_e = sc_e;
                    end
                end
            end
            ITER: begin
                if (it_done) begin
                    wr         = 1'b1;
                    wr_q       = it_q;
                    wr_v       = it_v;
`ifdef SEQ_ALU_MULHI_EN
                    wr_hi      = it_hi;
`endif
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_r        <= '0;
            out_valid_r <= 1'b0;
            q_r         <= '0;
            f_r         <= '0;
`ifdef SEQ_ALU_MULHI_EN
            qhi_r       <= '0;
`endif
        end else begin
            state       <= next_state;
            out_valid_r <= wr;
            if (start) begin
                op_r <= bus.ALUControl;
            end
            if (wr) begin
                q_r        <= wr_q;
                f_r[FLG_N] <= wr_q[N-1];
                f_r[FLG_Z] <= ~|wr_q;
                f_r[FLG_C] <= wr_c;
                f_r[FLG_V] <= wr_v;
                f_r[FLG_E] <= wr_e;
`ifdef SEQ_ALU_MULHI_EN
                qhi_r      <= wr_hi;
`endif
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.Q         = q_r;
    assign bus.F         = f_r;
`ifdef SEQ_ALU_MULHI_EN
    assign bus.Q_hi      = qhi_r;
`endif

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered, multi-cycle successor to the combinational 10-op ALU.
- Same op set and 5-bit op code, now at arbitrary width N.
- Single-cycle ops (add/sub/logic/shift) return after one clock.
- Multiply and divide/modulo use iterative shift-add and restoring-divide, N cycles each.
- A valid/ready input handshake and a registered result with a full flag set (N, Z, C, V, E) let it sit between the register file and writeback in the datapath.

Parameters:
- N, 4: operand and result width (N >= 2).
- CW, $clog2(N+1): iteration counter width (derived, localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept an op this cycle.
- A  in  N  operand A.
- B  in  N  operand B; also the shift amount.
- ALUControl  in  5  op code.
- out_valid  out  1  one-cycle pulse: Q/F hold a new result.
- Q  out  N  result.
- F  out  5  flags {N,Z,C,V,E}, F[4]=N … F[0]=E.

Behaviour:
- Op codes: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 and, 6 or, 7 xor, 8 sll, 9 srl.
  - Codes 10–31 are illegal: Q=0, F.E=1, single-cycle.
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, Q=0, F=0, counter=0.
- Accept: in_valid && in_ready at a rising edge. Operands and op are latched; later input changes are ignored.
- FSM states: IDLE, ITER.
  - IDLE, single-cycle op accepted: Q/F written at the accept edge; out_valid=1 for the following cycle; stay IDLE.
  - IDLE, mul/div/mod accepted with B!=0: go to ITER, counter=0, in_ready=0.
  - ITER: one iteration per clock. After iteration N-1: write Q/F, go to IDLE, out_valid=1 next cycle.
  - Latency is exactly N+1 clocks from the accept edge to the out_valid cycle.
- in_ready = (state==IDLE). It is high during the out_valid cycle, so single-cycle ops sustain one result per clock.
- No output backpressure. Q/F hold until the next result.
- Add: Q=(A+B) mod 2^N. C = carry out. V = signed overflow.
- Sub: Q=(A-B) mod 2^N. C=1 iff A>=B (unsigned, no borrow). V = signed overflow.
- Mul: unsigned. Q = low N bits of the product. V=1 iff the high N bits are nonzero. C=0.
- Div/mod: unsigned restoring. Q = quotient / remainder. C=V=0.
  - B==0: single-cycle. Div Q = all ones, mod Q = A, E=1.
- Logic ops: C=V=0.
- Shifts: logical, amount = B as unsigned. Amount >= N gives Q=0. C=V=0.
- For all ops: F.N=Q[N-1], F.Z=(Q==0). E=0 except for divide-by-zero and illegal op.
- Reset mid-ITER aborts the op: no out_valid, Q/F cleared.

Optional Feature:
- Macro: SEQ_ALU_MULHI_EN.
- Defined: extra output port Q_hi (N bits) carries the high half of the product, registered with Q; Q_hi=0 for all other ops and reset to 0. V for mul is still computed.
- Undefined: no Q_hi port; the high half is discarded except for the V flag.

Decomposition:
- Package seq_alu_pkg:
  - op enum (OP_ADD…OP_SRL) as logic[4:0].
  - flag index constants FLG_N=4, FLG_Z=3, FLG_C=2, FLG_V=1, FLG_E=0.
  - state enum {IDLE, ITER}.
- Sub-module seq_alu_iter:
  - Shared 2N-bit shift register datapath plus counter, running shift-add or restoring-divide per a mode bit.
  - Signals: start, done, product/quotient/remainder outputs.
- Top module holds the FSM, single-cycle ops, flag logic and output registers.

Test Plan:
- N=4, add A=7 B=9 -> next cycle out_valid=1, Q=0, F: Z=1, C=1, V=0, N=0.
- sub A=3 B=5 -> Q=0xE, N=1, C=0, V=0. Then A=7 B=0xF (7-(-1)) -> Q=8, V=1.
- mul A=6 B=6 -> in_ready low 4 cycles, out_valid exactly 5 cycles after accept, Q=4, V=1.
  - With SEQ_ALU_MULHI_EN: Q_hi=2.
- div A=13 B=4 -> Q=3 after 5 cycles. mod -> Q=1. div B=0 -> next cycle Q=0xF, E=1.
- sll A=3 B=2 -> Q=0xC. srl A=0xF B=4 -> Q=0, Z=1. op=12 -> Q=0, E=1.
- Start mul A=5 B=3, assert rst_n=0 on the 2nd ITER cycle -> no out_valid; Q=0, F=0.
  - After release: in_ready=1; a new add 1+1 gives Q=2.
